id_stage_gen: RTL and testbench
===============================

ID_STAGE_GEN -- requirements
Module: id_stage_gen

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, datapath width; NREG, default 32, register count (power of 2, ≥8); RA = $clog2(NREG), register index width.
REQ-002 Ports SHALL be, clock and reset first: clk in 1 clock; reset in 1 reset, asynchronous active-high.
REQ-003 Fetch inputs SHALL be: InstrF in 32 fetched instruction; PCPlus4F in XLEN PC+4 of that instruction.
REQ-004 Hazard inputs SHALL be: StallD in 1 hold IF/ID; ForwardAD, ForwardBD in 2 each, with 00 = regfile, 01 = ALUOutM, 10 = ResultW, 11 = regfile.
REQ-005 Writeback and memory inputs SHALL be: RegWriteW in 1; WriteRegW in RA; ResultW in XLEN; ALUOutM in XLEN.
REQ-006 Outputs SHALL be: InstrD out 32; ValidD out 1; PCPlus4D out XLEN; RsD, RtD, RdD out RA each; srcaD, srcbD, SignImmD, PCBranchD, jumpdst out XLEN each; PCSrcD out 2; FlushF out 1; BranchD, JumpD out 1 each.
REQ-007 Control outputs SHALL be: RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD out 1 each; ALUControlD out 3.
REQ-008 Perf outputs SHALL be: CntBrTaken, CntJump, CntStall out 32 each.

Function
REQ-009 IF/ID register SHALL capture InstrF and PCPlus4F on rising clk, setting ValidD=1, when StallD=0 and FlushF=0.
REQ-010 When StallD=1, IF/ID SHALL hold its value, with StallD taking priority over FlushF.
REQ-011 When StallD=0 and FlushF=1, IF/ID SHALL load InstrD=0 and ValidD=0 (bubble).
REQ-012 When ValidD=0, all control outputs, BranchD and JumpD SHALL be 0, and PCSrcD SHALL be 00.
REQ-013 Register file SHALL hold NREG×XLEN entries, written on rising clk when RegWriteW=1 and WriteRegW≠0.
REQ-014 Register 0 SHALL always read 0.
REQ-015 Regfile reads SHALL be combinational with write-first bypass: same-cycle write to the read index returns ResultW.
REQ-016 srcaD and srcbD SHALL be the 3-way forwarding mux output selected by ForwardAD/ForwardBD.
REQ-017 SignImmD SHALL be InstrD[15:0] sign-extended to XLEN.
REQ-018 PCBranchD SHALL be PCPlus4D + (SignImmD<<2), modulo 2^XLEN.
REQ-019 Decoded ops SHALL be: R-type, lw, sw, addi, beq, bne, j, jr (R-type funct 001000); other opcodes decode to all-zero control.
REQ-020 jumpdst SHALL be {PCPlus4D[XLEN-1:28], InstrD[25:0], 2'b00} for j, and srcaD for jr.
REQ-021 Branch condition SHALL be: beq taken when srcaD==srcbD; bne taken when srcaD!=srcbD.
REQ-022 PCSrcD SHALL be 01 when a branch is taken, else 10 when jump (j or jr), else 00; it SHALL be forced to 00 while StallD=1.
REQ-023 FlushF SHALL equal |PCSrcD.
REQ-024 All decode and branch-resolution outputs SHALL be combinational from IF/ID contents, i.e. one-cycle decode latency.

Reset
REQ-025 reset SHALL asynchronously clear InstrD, PCPlus4D, ValidD, all regfile entries and all counters to 0.
REQ-026 Reset asserted mid-stall SHALL override the stall, leaving ValidD=0 after reset.

Configuration
REQ-027 Macro ID_PERF_CNT_EN SHALL, when defined, enable three saturating 32-bit counters.
REQ-028 CntBrTaken SHALL increment each cycle PCSrcD==01.
REQ-029 CntJump SHALL increment each cycle PCSrcD==10.
REQ-030 CntStall SHALL increment each cycle StallD=1 and ValidD=1.
REQ-031 Each counter SHALL hold at 0xFFFFFFFF.
REQ-032 Without ID_PERF_CNT_EN, the counters SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-033 Package id_pkg SHALL hold opcode/funct localparams (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE, OP_J, FN_JR), the forward-select enum fwd_sel_t and the ctrl_t struct.
REQ-034 The sole sub-module SHALL be id_regfile (parameters XLEN, NREG; write-first bypass; async reset).

Verification
REQ-035 Reset check: reset=1 mid-stream -> ValidD=0, InstrD=0, PCSrcD=00, reads of r5 return 0.
REQ-036 Bypass check: RegWriteW=1, WriteRegW=3, ResultW=0x1234, InstrD reads rs=3 same cycle -> srcaD=0x1234; write to r0 -> r0 still reads 0.
REQ-037 Taken beq: r1=r2=7, beq offset 4, PCPlus4D=0x100 -> PCSrcD=01, PCBranchD=0x110, FlushF=1, next ValidD=0.
REQ-038 bne with forwarding: ForwardAD=01, ALUOutM=5, r2=5 -> PCSrcD=00; ALUOutM=6 -> PCSrcD=01.
REQ-039 Stall vs flush: StallD=1 with taken branch in ID -> PCSrcD=00, IF/ID holds; release -> branch resolves next cycle.
REQ-040 jr r31=0x400 -> PCSrcD=10, jumpdst=0x400; with ID_PERF_CNT_EN, CntJump increments by 1.

Source files
------------

// File: rtl/id_pkg.sv
// id_pkg -- shared definitions for the ID stage.
// Holds the opcode/funct encodings, ALU control codes, the operand forwarding
// select enum, the decoded-control struct and the main decoder function.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // 11 selects the register file, same as 00.
  typedef enum logic [1:0] {
    FWD_RF     = 2'b00,
    FWD_ALUM   = 2'b01,
    FWD_RESW   = 2'b10,
    FWD_RF_ALT = 2'b11
  } fwd_sel_t;

  typedef struct packed {
    logic       reg_write;
    logic       memto_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_control;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic       jump_reg;
  } ctrl_t;

  function automatic logic [2:0] alu_from_funct(input logic [5:0] funct);
    case (funct)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // Unknown opcodes fall out as all-zero control.
  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        if (funct == FN_JR) begin
          c.jump     = 1'b1;
          c.jump_reg = 1'b1;
        end else begin
          c.reg_write   = 1'b1;
          c.reg_dst     = 1'b1;
          c.alu_control = alu_from_funct(funct);
        end
      end
      OP_LW: begin
        c.reg_write   = 1'b1;
        c.memto_reg   = 1'b1;
        c.alu_src     = 1'b1;
        c.alu_control = ALU_ADD;
      end
      OP_SW: begin
        c.mem_write   = 1'b1;
        c.alu_src     = 1'b1;
        c.alu_control = ALU_ADD;
      end
      OP_ADDI: begin
        c.reg_write   = 1'b1;
        c.alu_src     = 1'b1;
        c.alu_control = ALU_ADD;
      end
      OP_BEQ: begin
        c.branch      = 1'b1;
        c.alu_control = ALU_SUB;
      end
      OP_BNE: begin
        c.branch      = 1'b1;
        c.branch_ne   = 1'b1;
        c.alu_control = ALU_SUB;
      end
      OP_J:    c.jump = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// id_regfile -- NREG x XLEN register file, two combinational read ports.
// Ports: clk, reset (async, active-high, clears every entry);
//   we/waddr/wdata write port (writes to index 0 are dropped);
//   raddr_a/raddr_b -> rdata_a/rdata_b. A read of the index being written in
//   the same cycle returns wdata (write-first bypass); index 0 reads 0.
module id_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RA   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [RA-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [RA-1:0]   raddr_a,
  input  logic [RA-1:0]   raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = regs[raddr_a];
    if (raddr_a == '0)                rdata_a = '0;
    else if (we && waddr == raddr_a)  rdata_a = wdata;
  end

  always_comb begin
    rdata_b = regs[raddr_b];
    if (raddr_b == '0)                rdata_b = '0;
    else if (we && waddr == raddr_b)  rdata_b = wdata;
  end

endmodule

// File: rtl/id_stage_gen.sv
// id_stage_gen -- pipeline decode stage: IF/ID register, register file,
// operand forwarding, main decoder and early branch/jump resolution.
// Ports: clk, reset (async active-high); fetch InstrF/PCPlus4F; hazard
//   StallD/ForwardAD/ForwardBD; writeback RegWriteW/WriteRegW/ResultW and
//   ALUOutM; decoded fields, operands, immediates, branch/jump targets,
//   PCSrcD/FlushF, control bits and three perf counters.
// Build option: define ID_PERF_CNT_EN to add saturating 32-bit counters for
//   taken branches, jumps and stalled valid instructions; otherwise the
//   counter outputs are constant 0.
module id_stage_gen
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RA   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     InstrF,
  input  logic [XLEN-1:0] PCPlus4F,
  input  logic            StallD,
  input  logic [1:0]      ForwardAD,
  input  logic [1:0]      ForwardBD,
  input  logic            RegWriteW,
  input  logic [RA-1:0]   WriteRegW,
  input  logic [XLEN-1:0] ResultW,
  input  logic [XLEN-1:0] ALUOutM,
  output logic [31:0]     InstrD,
  output logic            ValidD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic [RA-1:0]   RsD,
  output logic [RA-1:0]   RtD,
  output logic [RA-1:0]   RdD,
  output logic [XLEN-1:0] srcaD,
  output logic [XLEN-1:0] srcbD,
  output logic [XLEN-1:0] SignImmD,
  output logic [XLEN-1:0] PCBranchD,
  output logic [XLEN-1:0] jumpdst,
  output logic [1:0]      PCSrcD,
  output logic            FlushF,
  output logic            BranchD,
  output logic            JumpD,
  output logic            RegWriteD,
  output logic            MemtoRegD,
  output logic            MemWriteD,
  output logic            ALUSrcD,
  output logic            RegDstD,
  output logic [2:0]      ALUControlD,
  output logic [31:0]     CntBrTaken,
  output logic [31:0]     CntJump,
  output logic [31:0]     CntStall
);

  logic [XLEN-1:0] rf_a, rf_b;
  ctrl_t           ctrl;
  logic            br_taken;

  // Stall wins over flush; a flush leaves a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      InstrD   <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      PCPlus4D <= PCPlus4F;
      if (FlushF) begin
        InstrD <= '0;
        ValidD <= 1'b0;
      end else begin
        InstrD <= InstrF;
        ValidD <= 1'b1;
      end
    end
  end

  assign RsD = RA'(InstrD[25:21]);
  assign RtD = RA'(InstrD[20:16]);
  assign RdD = RA'(InstrD[15:11]);

  id_regfile #(.XLEN(XLEN), .NREG(NREG), .RA(RA)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (RegWriteW),
    .waddr   (WriteRegW),
    .wdata   (ResultW),
    .raddr_a (RsD),
    .raddr_b (RtD),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

  always_comb begin
    case (fwd_sel_t'(ForwardAD))
      FWD_ALUM: srcaD = ALUOutM;
      FWD_RESW: srcaD = ResultW;
      default:  srcaD = rf_a;
    endcase
    case (fwd_sel_t'(ForwardBD))
      FWD_ALUM: srcbD = ALUOutM;
      FWD_RESW: srcbD = ResultW;
      default:  srcbD = rf_b;
    endcase
  end

  assign SignImmD  = {{(XLEN-16){InstrD[15]}}, InstrD[15:0]};
  assign PCBranchD = PCPlus4D + (SignImmD << 2);
  assign jumpdst   = ctrl.jump_reg ? srcaD : {PCPlus4D[XLEN-1:28], InstrD[25:0], 2'b00};

  // A bubble decodes to no control at all.
  always_comb begin
    ctrl = '0;
    if (ValidD) ctrl = decode(InstrD[31:26], InstrD[5:0]);
  end

  assign RegWriteD   = ctrl.reg_write;
  assign MemtoRegD   = ctrl.memto_reg;
  assign MemWriteD   = ctrl.mem_write;
  assign ALUSrcD     = ctrl.alu_src;
  assign RegDstD     = ctrl.reg_dst;
  assign ALUControlD = ctrl.alu_control;
  assign BranchD     = ctrl.branch;
  assign JumpD       = ctrl.jump;

  assign br_taken = ctrl.branch && ((srcaD == srcbD) != ctrl.branch_ne);

  // Redirects are suppressed while stalled so the held instruction resolves
  // exactly once, on the cycle it is released.
  always_comb begin
    PCSrcD = 2'b00;
    if (!StallD) begin
      if (br_taken)       PCSrcD = 2'b01;
      else if (ctrl.jump) PCSrcD = 2'b10;
    end
  end

  assign FlushF = |PCSrcD;

`ifdef ID_PERF_CNT_EN
  logic [31:0] cnt_br, cnt_jmp, cnt_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_br    <= '0;
      cnt_jmp   <= '0;
      cnt_stall <= '0;
    end else begin
      if (PCSrcD == 2'b01 && cnt_br != '1)       cnt_br    <= cnt_br + 32'd1;
      if (PCSrcD == 2'b10 && cnt_jmp != '1)      cnt_jmp   <= cnt_jmp + 32'd1;
      if (StallD && ValidD && cnt_stall != '1)   cnt_stall <= cnt_stall + 32'd1;
    end
  end

  assign CntBrTaken = cnt_br;
  assign CntJump    = cnt_jmp;
  assign CntStall   = cnt_stall;
`else
  assign CntBrTaken = '0;
  assign CntJump    = '0;
  assign CntStall   = '0;
`endif

endmodule

// File: tb/tb_id_stage_gen.sv
// tb_id_stage_gen -- self-checking bench for id_stage_gen: directed scenarios
// followed by randomized instruction/hazard traffic, all checked against a
// behavioural model of the decode stage kept here.
module tb_id_stage_gen;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RA   = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [31:0]     InstrF;
  logic [XLEN-1:0] PCPlus4F;
  logic            StallD;
  logic [1:0]      ForwardAD, ForwardBD;
  logic            RegWriteW;
  logic [RA-1:0]   WriteRegW;
  logic [XLEN-1:0] ResultW, ALUOutM;
  logic [31:0]     InstrD;
  logic            ValidD;
  logic [XLEN-1:0] PCPlus4D;
  logic [RA-1:0]   RsD, RtD, RdD;
  logic [XLEN-1:0] srcaD, srcbD, SignImmD, PCBranchD, jumpdst;
  logic [1:0]      PCSrcD;
  logic            FlushF, BranchD, JumpD;
  logic            RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
  logic [2:0]      ALUControlD;
  logic [31:0]     CntBrTaken, CntJump, CntStall;

  id_stage_gen #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .reset(reset), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
    .StallD(StallD), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
    .ALUOutM(ALUOutM), .InstrD(InstrD), .ValidD(ValidD), .PCPlus4D(PCPlus4D),
    .RsD(RsD), .RtD(RtD), .RdD(RdD), .srcaD(srcaD), .srcbD(srcbD),
    .SignImmD(SignImmD), .PCBranchD(PCBranchD), .jumpdst(jumpdst),
    .PCSrcD(PCSrcD), .FlushF(FlushF), .BranchD(BranchD), .JumpD(JumpD),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .ALUControlD(ALUControlD),
    .CntBrTaken(CntBrTaken), .CntJump(CntJump), .CntStall(CntStall)
  );

  always #5 clk = ~clk;

  // model state
  logic [31:0] m_rf [NREG];
  logic [31:0] m_instr, m_pc4;
  logic        m_valid;
  int          m_pcsrc;
  logic [31:0] m_cbr, m_cjmp, m_cstall;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_rf(input int idx);
    if (idx == 0) return 32'd0;
    if (RegWriteW && int'(WriteRegW) == idx) return ResultW;
    return m_rf[idx];
  endfunction

  function automatic logic [31:0] fwd(input logic [1:0] sel, input int idx);
    if (sel == 2'd1) return ALUOutM;
    if (sel == 2'd2) return ResultW;
    return rd_rf(idx);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) m_rf[i] = 32'd0;
    m_instr = 0; m_pc4 = 0; m_valid = 0; m_pcsrc = 0;
    m_cbr = 0; m_cjmp = 0; m_cstall = 0;
  endtask

  task automatic check_id(input string tag);
    int op, fn, rs, rt, rd, simm;
    logic [31:0] a, b, pcbr, jd;
    logic is_r, is_jr, is_j, is_beq, is_bne, taken, jmp;
    logic rw, mtr, mw, asrc, rdst;
    int alu;
    op = int'(m_instr[31:26]); fn = int'(m_instr[5:0]);
    rs = int'(m_instr[25:21]); rt = int'(m_instr[20:16]); rd = int'(m_instr[15:11]);
    simm = int'(m_instr[15:0]);
    if (simm >= 32768) simm -= 65536;
    a = fwd(ForwardAD, rs);
    b = fwd(ForwardBD, rt);
    pcbr = m_pc4 + 32'(simm * 4);
    is_r   = m_valid && op == 0;
    is_jr  = is_r && fn == 8;
    is_j   = m_valid && op == 2;
    is_beq = m_valid && op == 4;
    is_bne = m_valid && op == 5;
    taken  = (is_beq && a == b) || (is_bne && a != b);
    jmp    = is_j || is_jr;
    m_pcsrc = StallD ? 0 : (taken ? 1 : (jmp ? 2 : 0));
    jd = is_jr ? a : ((m_pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2));
    rw = 0; mtr = 0; mw = 0; asrc = 0; rdst = 0; alu = 0;
    if (is_r && !is_jr) begin
      rw = 1; rdst = 1;
      alu = (fn == 32'h22) ? 6 : (fn == 32'h24) ? 0 : (fn == 32'h25) ? 1 :
            (fn == 32'h2A) ? 7 : 2;
    end
    if (m_valid && op == 32'h23) begin rw = 1; mtr = 1; asrc = 1; alu = 2; end
    if (m_valid && op == 32'h2B) begin mw = 1; asrc = 1; alu = 2; end
    if (m_valid && op == 32'h08) begin rw = 1; asrc = 1; alu = 2; end
    if (is_beq || is_bne) alu = 6;

    chk({tag, ":ValidD"},    32'(ValidD), 32'(m_valid));
    chk({tag, ":InstrD"},    InstrD, m_instr);
    chk({tag, ":PCPlus4D"},  PCPlus4D, m_pc4);
    chk({tag, ":RsD/RtD/RdD"}, {17'd0, RsD, RtD, RdD}, 32'((rs << 10) | (rt << 5) | rd));
    chk({tag, ":srcaD"},     srcaD, a);
    chk({tag, ":srcbD"},     srcbD, b);
    chk({tag, ":SignImmD"},  SignImmD, 32'(simm));
    chk({tag, ":PCBranchD"}, PCBranchD, pcbr);
    chk({tag, ":PCSrcD"},    32'(PCSrcD), 32'(m_pcsrc));
    chk({tag, ":FlushF"},    32'(FlushF), 32'(m_pcsrc != 0));
    chk({tag, ":Br/Jmp"},    {30'd0, BranchD, JumpD}, {30'd0, is_beq || is_bne, jmp});
    chk({tag, ":ctrl"},      {24'd0, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD},
                             {24'd0, rw, mtr, mw, asrc, rdst, 3'(alu)});
    if (jmp) chk({tag, ":jumpdst"}, jumpdst, jd);
`ifdef ID_PERF_CNT_EN
    chk({tag, ":cnt"}, CntBrTaken ^ (CntJump << 11) ^ (CntStall << 22),
        m_cbr ^ (m_cjmp << 11) ^ (m_cstall << 22));
`else
    chk({tag, ":cnt"}, CntBrTaken | CntJump | CntStall, 32'd0);
`endif
  endtask

  task automatic settle(input string tag);
    #1;
    check_id(tag);
  endtask

  // Advance one clock edge; model next state uses the values held before it.
  task automatic tick();
    logic [31:0] n_instr, n_pc4;
    logic n_valid, wr;
    int widx;
    logic [31:0] wval;
    n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid;
    if (!StallD) begin
      n_pc4 = PCPlus4F;
      if (m_pcsrc != 0) begin n_instr = 0; n_valid = 0; end
      else begin n_instr = InstrF; n_valid = 1; end
    end
    wr = RegWriteW && WriteRegW != 0;
    widx = int'(WriteRegW);
    wval = ResultW;
    if (m_pcsrc == 1 && m_cbr != 32'hFFFF_FFFF) m_cbr++;
    if (m_pcsrc == 2 && m_cjmp != 32'hFFFF_FFFF) m_cjmp++;
    if (StallD && m_valid && m_cstall != 32'hFFFF_FFFF) m_cstall++;
    @(posedge clk);
    m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid;
    if (wr) m_rf[widx] = wval;
    #1;
  endtask

  task automatic cyc(input string tag);
    settle(tag);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_clear();
    check_id("rst");
    @(posedge clk);
    #1;
    check_id("rst_hold");
    reset = 1'b0;
  endtask

  task automatic wr_reg(input int idx, input logic [31:0] val);
    RegWriteW = 1'b1; WriteRegW = RA'(idx); ResultW = val;
    cyc("wr");
    RegWriteW = 1'b0;
  endtask

  function automatic logic [31:0] i_type(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] rand_instr();
    int rs, rt, rd;
    logic [31:0] r;
    rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
    r = $urandom;
    case ($urandom_range(0, 12))
      0:  return r_type(rs, rt, rd, 32'h20);
      1:  return r_type(rs, rt, rd, 32'h22);
      2:  return r_type(rs, rt, rd, 32'h24);
      3:  return r_type(rs, rt, rd, 32'h25);
      4:  return r_type(rs, rt, rd, 32'h2A);
      5:  return r_type(rs, 0, 0, 8);
      6:  return i_type(32'h23, rs, rt, int'(r[15:0]));
      7:  return i_type(32'h2B, rs, rt, int'(r[15:0]));
      8:  return i_type(32'h08, rs, rt, int'(r[15:0]));
      9:  return i_type(4, rs, rt, int'(r[15:0]));
      10: return i_type(5, rs, rt, int'(r[15:0]));
      11: return {6'd2, r[25:0]};
      default: return r;
    endcase
  endfunction

  logic [31:0] cj_before;

  initial begin
    InstrF = 0; PCPlus4F = 0; StallD = 0; ForwardAD = 0; ForwardBD = 0;
    RegWriteW = 0; WriteRegW = 0; ResultW = 0; ALUOutM = 0;
    do_reset();

    // write-first bypass and r0
    InstrF = r_type(3, 0, 1, 32'h20); PCPlus4F = 32'h0000_0040;
    cyc("load_add");
    RegWriteW = 1; WriteRegW = 5'd3; ResultW = 32'h1234;
    InstrF = r_type(0, 3, 2, 32'h20);
    settle("bypass");
    chk("bypass_srca", srcaD, 32'h1234);
    tick();
    RegWriteW = 1; WriteRegW = 5'd0; ResultW = 32'hDEAD_BEEF;
    settle("r0_write");
    chk("r0_reads_0", srcaD, 32'd0);
    chk("r3_kept", srcbD, 32'h1234);
    tick();
    RegWriteW = 0;

    // taken beq
    InstrF = 0;
    wr_reg(1, 7);
    wr_reg(2, 7);
    InstrF = i_type(4, 1, 2, 4); PCPlus4F = 32'h100;
    cyc("load_beq");
    InstrF = r_type(1, 2, 3, 32'h20); PCPlus4F = 32'h104;
    settle("beq");
    chk("beq_pcsrc", 32'(PCSrcD), 32'd1);
    chk("beq_target", PCBranchD, 32'h110);
    chk("beq_flush", 32'(FlushF), 32'd1);
    tick();
    chk("beq_bubble", 32'(ValidD), 32'd0);
    cyc("after_bubble");

    // bne with forwarding
    wr_reg(2, 5);
    InstrF = i_type(5, 1, 2, 32'hFFFC); PCPlus4F = 32'h200;
    cyc("load_bne");
    InstrF = 0;
    ForwardAD = 2'b01; ALUOutM = 5;
    settle("bne_eq");
    chk("bne_not_taken", 32'(PCSrcD), 32'd0);
    ALUOutM = 6;
    settle("bne_ne");
    chk("bne_taken", 32'(PCSrcD), 32'd1);
    tick();
    ForwardAD = 2'b00;
    cyc("post_bne");

    // stall holds a taken branch
    wr_reg(1, 5);
    InstrF = i_type(4, 1, 2, 8); PCPlus4F = 32'h300;
    cyc("load_beq2");
    InstrF = r_type(4, 4, 4, 32'h20); PCPlus4F = 32'h304;
    StallD = 1;
    settle("stall");
    chk("stall_no_redirect", 32'(PCSrcD), 32'd0);
    tick();
    chk("stall_hold", InstrD, i_type(4, 1, 2, 8));
    StallD = 0;
    settle("release");
    chk("release_taken", 32'(PCSrcD), 32'd1);
    tick();

    // jr r31
    InstrF = 0;
    wr_reg(31, 32'h400);
    InstrF = r_type(31, 0, 0, 8); PCPlus4F = 32'h500;
    cyc("load_jr");
    InstrF = 0;
    cj_before = CntJump;
    settle("jr");
    chk("jr_pcsrc", 32'(PCSrcD), 32'd2);
    chk("jr_dst", jumpdst, 32'h400);
    tick();
`ifdef ID_PERF_CNT_EN
    chk("jr_cnt_inc", CntJump - cj_before, 32'd1);
`else
    chk("jr_cnt_zero", CntJump, 32'd0);
`endif

    // reset during stall, then r5 reads 0
    wr_reg(5, 32'hABC);
    InstrF = r_type(5, 5, 0, 32'h20);
    cyc("load_r5");
    StallD = 1;
    cyc("stall_r5");
    do_reset();
    chk("rst_valid", 32'(ValidD), 32'd0);
    chk("rst_instr", InstrD, 32'd0);
    chk("rst_pcsrc", 32'(PCSrcD), 32'd0);
    StallD = 0;
    cyc("reload_r5");
    settle("r5_cleared");
    chk("r5_reads_0", srcaD, 32'd0);
    tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      InstrF    = rand_instr();
      PCPlus4F  = $urandom & 32'hFFFF_FFFC;
      StallD    = ($urandom_range(0, 4) == 0);
      ForwardAD = 2'($urandom_range(0, 3));
      ForwardBD = 2'($urandom_range(0, 3));
      RegWriteW = $urandom_range(0, 1) == 1;
      WriteRegW = RA'($urandom_range(0, 7));
      ResultW   = $urandom_range(0, 3);
      ALUOutM   = $urandom_range(0, 3);
      cyc("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
